// File: rtl/sparse_act_pingpong_ram_if.sv
// sparse_act_pingpong_ram_if: signal bundle for the ping-pong activation store
//   master: drives load/wb/stream starts, done, swap, write beats (in_*) and read requests (rd_req/rd_ch/rd_off)
//   slave : returns in_ready, the read beat (rd_vld/rd_mask/rd_data/rd_idx), ch_count, in_bank, ovf and state
interface sparse_act_pingpong_ram_if #(
   parameter int NUM_CH   = 16,
   parameter int DEPTH    = 64,
   parameter int DATA_W   = 16,
   parameter int IDX_W    = 4,
   parameter int WR_LANES = 4,
   parameter int LANES    = 4
);
   localparam int CW   = $clog2(NUM_CH);
   localparam int PW   = $clog2(DEPTH);
   localparam int CNTW = PW + 1;
   logic                      load_start;
   logic                      wb_start;
   logic                      stream_start;
   logic                      done;
   logic                      swap;
   logic                      in_valid;
   logic                      in_ready;
   logic [CW-1:0]             in_ch;
   logic [WR_LANES-1:0]       in_mask;
   logic [WR_LANES*DATA_W-1:0] in_data;
   logic [WR_LANES*IDX_W-1:0] in_idx;
   logic                      rd_req;
   logic [CW-1:0]             rd_ch;
   logic [PW-1:0]             rd_off;
   logic                      rd_vld;
   logic [LANES-1:0]          rd_mask;
   logic [LANES*DATA_W-1:0]   rd_data;
   logic [LANES*IDX_W-1:0]    rd_idx;
   logic [NUM_CH*CNTW-1:0]    ch_count;
   logic                      in_bank;
   logic                      ovf;
   logic [1:0]                state;
   modport master (
      output load_start, wb_start, stream_start, done, swap, in_valid, in_ch, in_mask, in_data, in_idx,
             rd_req, rd_ch, rd_off,
      input  in_ready, rd_vld, rd_mask, rd_data, rd_idx, ch_count, in_bank, ovf, state
   );
   modport slave (
      input  load_start, wb_start, stream_start, done, swap, in_valid, in_ch, in_mask, in_data, in_idx,
             rd_req, rd_ch, rd_off,
      output in_ready, rd_vld, rd_mask, rd_data, rd_idx, ch_count, in_bank, ovf, state
   );
endinterface

// File: rtl/sparse_act_pingpong_ram.sv
// sparse_act_pingpong_ram: double-buffered compressed (value, index) activation store with per-channel counts
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of sparse_act_pingpong_ram_if (control pulses, write beats, read port, status)
module sparse_act_pingpong_ram #(
   parameter int NUM_CH   = 16,
   parameter int DEPTH    = 64,
   parameter int DATA_W   = 16,
   parameter int IDX_W    = 4,
   parameter int WR_LANES = 4,
   parameter int LANES    = 4
) (
   input logic                      clk,
   input logic                      rst,
   sparse_act_pingpong_ram_if.slave bus
);
   localparam int PW   = $clog2(DEPTH);
   localparam int CNTW = PW + 1;
   localparam int AW   = CNTW + 1;
   localparam int EW   = DATA_W + IDX_W;
   typedef enum logic [1:0] {S_IDLE = 2'd0, S_LOAD = 2'd1, S_STREAM = 2'd2, S_WB = 2'd3} state_e;
   state_e                  state_q, state_d;
   logic                    in_ready_q, bank_q, ovf_q, rd_vld_q;
   logic [LANES-1:0]        rd_mask_q, rd_mask_d;
   logic [LANES*DATA_W-1:0] rd_data_q, rd_data_d;
   logic [LANES*IDX_W-1:0]  rd_idx_q, rd_idx_d;
   logic [CNTW-1:0]         cnt_q [2][NUM_CH];
   logic [EW-1:0]           mem_q [2][NUM_CH][DEPTH];
   logic                    idle, accept, wr_bank, ovf_hit, rd_go;
   logic [AW-1:0]           fill;
   logic [PW-1:0]           pos [WR_LANES];
   logic [WR_LANES-1:0]     wen;
   logic [CNTW-1:0]         new_cnt;
   always_comb begin
      idle    = state_q == S_IDLE;
      state_d = state_q;
      if (idle)
         state_d = bus.load_start ? S_LOAD : bus.wb_start ? S_WB : bus.stream_start ? S_STREAM : S_IDLE;
      else if (bus.done)
         state_d = S_IDLE;
   end
   // Compaction: each masked-on lane takes the next free slot; the running fill also yields the saturated count.
   always_comb begin
      accept  = bus.in_valid && in_ready_q;
      wr_bank = (state_q == S_WB) ? ~bank_q : bank_q;
      fill    = AW'(cnt_q[wr_bank][bus.in_ch]);
      for (int l = 0; l < WR_LANES; l++) begin
         pos[l] = fill[PW-1:0];
         wen[l] = accept && bus.in_mask[l] && fill < AW'(DEPTH);
         fill   = fill + AW'(bus.in_mask[l]);
      end
      ovf_hit = accept && fill > AW'(DEPTH);
      new_cnt = (fill > AW'(DEPTH)) ? CNTW'(DEPTH) : fill[CNTW-1:0];
   end
   // Count never exceeds DEPTH, so offset < count also rules out offsets past the end of the channel.
   always_comb begin
      rd_go     = state_q == S_STREAM && bus.rd_req;
      rd_mask_d = '0;
      rd_data_d = '0;
      rd_idx_d  = '0;
      for (int j = 0; j < LANES; j++) begin
         rd_mask_d[j]                  = rd_go && (CNTW'(bus.rd_off) + CNTW'(j)) < cnt_q[bank_q][bus.rd_ch];
         rd_data_d[j*DATA_W +: DATA_W] = rd_mask_d[j] ? mem_q[bank_q][bus.rd_ch][bus.rd_off + PW'(j)][DATA_W-1:0] : '0;
         rd_idx_d[j*IDX_W +: IDX_W]    = rd_mask_d[j] ? mem_q[bank_q][bus.rd_ch][bus.rd_off + PW'(j)][EW-1:DATA_W] : '0;
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         in_ready_q <= 1'b0;
         bank_q     <= 1'b0;
         ovf_q      <= 1'b0;
         rd_vld_q   <= 1'b0;
         rd_mask_q  <= '0;
         rd_data_q  <= '0;
         rd_idx_q   <= '0;
         for (int b = 0; b < 2; b++)
            for (int c = 0; c < NUM_CH; c++)
               cnt_q[b][c] <= '0;
      end else begin
         state_q    <= state_d;
         in_ready_q <= state_d == S_LOAD || state_d == S_WB;
         rd_vld_q   <= rd_go;
         rd_mask_q  <= rd_mask_d;
         rd_data_q  <= rd_data_d;
         rd_idx_q   <= rd_idx_d;
         if (idle && bus.swap)
            bank_q <= ~bank_q;
         if (idle && (bus.load_start || bus.wb_start)) begin
            ovf_q <= 1'b0;
            for (int c = 0; c < NUM_CH; c++)
               cnt_q[bus.load_start ? bank_q : ~bank_q][c] <= '0;
         end
         if (accept)
            cnt_q[wr_bank][bus.in_ch] <= new_cnt;
         if (ovf_hit)
            ovf_q <= 1'b1;
      end
   end
   always_ff @(posedge clk)
      for (int l = 0; l < WR_LANES; l++)
         if (wen[l])
            mem_q[wr_bank][bus.in_ch][pos[l]] <= {bus.in_idx[l*IDX_W +: IDX_W], bus.in_data[l*DATA_W +: DATA_W]};
   always_comb begin
      bus.ch_count = '0;
      for (int c = 0; c < NUM_CH; c++)
         bus.ch_count[c*CNTW +: CNTW] = cnt_q[bank_q][c];
   end
   assign bus.in_ready = in_ready_q;
   assign bus.rd_vld   = rd_vld_q;
   assign bus.rd_mask  = rd_mask_q;
   assign bus.rd_data  = rd_data_q;
   assign bus.rd_idx   = rd_idx_q;
   assign bus.in_bank  = bank_q;
   assign bus.ovf      = ovf_q;
   assign bus.state    = state_q;
endmodule
